// File: rtl/counter_datapath.sv
// Datapath for the sum-of-0..LIMIT counter: i/sum registers, one shared adder, output register.
// Optional build macro DP_SAT_EN: saturating adder plus sticky overflow flag ovf.
module counter_datapath #(
  parameter int DATA_W = 8,
  parameter int LIMIT  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sumSrcMuxSel,
  input  logic              iSrcMuxSel,
  input  logic              sumLoad,
  input  logic              iLoad,
  input  logic              outLoad,
  input  logic              adderSrcMuxSel,
  output logic              iLe10,
  output logic [DATA_W-1:0] outData,
  output logic              outValid,
  output logic              ovf
);

  localparam logic [DATA_W-1:0] LIMIT_V = DATA_W'(LIMIT);
  localparam logic [DATA_W-1:0] ZERO_V  = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONE_V   = {{(DATA_W-1){1'b0}}, 1'b1};

  // i must be able to step one past LIMIT without wrapping, or iLe10 never falls
  generate
    if ((longint'(LIMIT) + 64'sd1) > ((64'sd1 <<< DATA_W) - 64'sd1)) begin : gLimitCheck
      $error("counter_datapath: LIMIT+1 must not exceed 2**DATA_W-1");
    end
  endgenerate

  logic [DATA_W-1:0] iVal_r;
  logic [DATA_W-1:0] sum_r;
  logic [DATA_W-1:0] opA_s;
  logic [DATA_W-1:0] opB_s;
  logic [DATA_W-1:0] adderRes_s;
  logic              adderSat_s;
  logic [DATA_W-1:0] sumNext_s;
  logic [DATA_W-1:0] iNext_s;

  // Shared adder operand selection
  always_comb begin
    opA_s = sum_r;
    opB_s = iVal_r;
    if (adderSrcMuxSel) begin
      opA_s = iVal_r;
      opB_s = ONE_V;
    end else begin
      opA_s = sum_r;
      opB_s = iVal_r;
    end
  end

`ifdef DP_SAT_EN
  function automatic logic [DATA_W:0] addWide(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic [DATA_W:0] sumWide_s;

  // Saturating adder: clamp to all-ones when the carry-out is set
  always_comb begin
    sumWide_s  = addWide(opA_s, opB_s);
    adderSat_s = sumWide_s[DATA_W];
    if (sumWide_s[DATA_W]) begin
      adderRes_s = {DATA_W{1'b1}};
    end else begin
      adderRes_s = sumWide_s[DATA_W-1:0];
    end
  end
`else
  // Wrapping adder, carry discarded
  always_comb begin
    adderRes_s = opA_s + opB_s;
    adderSat_s = 1'b0;
  end
`endif

  // Register D-input muxes
  always_comb begin
    sumNext_s = ZERO_V;
    iNext_s   = ZERO_V;
    if (sumSrcMuxSel) begin
      sumNext_s = adderRes_s;
    end else begin
      sumNext_s = ZERO_V;
    end
    if (iSrcMuxSel) begin
      iNext_s = adderRes_s;
    end else begin
      iNext_s = ZERO_V;
    end
  end

  // Loop index register
  always_ff @(posedge clk) begin
    if (reset) begin
      iVal_r <= ZERO_V;
    end else if (iLoad) begin
      iVal_r <= iNext_s;
    end else begin
      iVal_r <= iVal_r;
    end
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r <= ZERO_V;
    end else if (sumLoad) begin
      sum_r <= sumNext_s;
    end else begin
      sum_r <= sum_r;
    end
  end

  // Output register and its one-cycle valid pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      outData  <= ZERO_V;
      outValid <= 1'b0;
    end else begin
      outValid <= outLoad;
      if (outLoad) begin
        outData <= sum_r;
      end else begin
        outData <= outData;
      end
    end
  end

`ifdef DP_SAT_EN
  logic ovfSet_s;
  logic ovfClr_s;

  // A saturated result only counts once it lands in a register
  always_comb begin
    ovfSet_s = adderSat_s & ((sumLoad & sumSrcMuxSel) | (iLoad & iSrcMuxSel));
    ovfClr_s = sumLoad & ~sumSrcMuxSel;
  end

  // Sticky overflow flag; a new overflow wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (ovfSet_s) begin
      ovf <= 1'b1;
    end else if (ovfClr_s) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ovf;
    end
  end
`else
  logic unusedSat_s;
  assign unusedSat_s = adderSat_s;
  assign ovf = 1'b0;
`endif

  assign iLe10 = (iVal_r <= LIMIT_V);

endmodule
